// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: 16-bit add/subtract computed one nibble per clock through a single 4-bit adder slice.
module nibble_serial_add_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_sub,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        c_out,
    output logic        ovf
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [1:0] idx;
    logic carry;
    logic [15:0] acc, op_a, op_b;
    logic [3:0] a_n, b_n, s_sum;
    logic s_co;
    logic accept;
    assign accept = (state != RUN) && start;
    assign a_n = op_a[{idx, 2'b00} +: 4];
    assign b_n = op_b[{idx, 2'b00} +: 4];
    assign {s_co, s_sum} = {1'b0, a_n} + {1'b0, b_n} + {4'b0000, carry};
    assign busy = state == RUN;
    assign done = state == DONE;
    always_comb begin
        state_n = state;
        if (accept) state_n = RUN;
        else if (state == DONE) state_n = IDLE;
        else if (state == RUN && idx == 2'd3) state_n = DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= 2'd0;
            carry  <= 1'b0;
            acc    <= 16'h0000;
            op_a   <= 16'h0000;
            op_b   <= 16'h0000;
            result <= 16'h0000;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_a  <= a;
                op_b  <= op_sub ? ~b : b;
                carry <= op_sub;
                idx   <= 2'd0;
            end else if (state == RUN) begin
                acc[{idx, 2'b00} +: 4] <= s_sum;
                carry <= s_co;
                idx   <= idx + 2'd1;
                if (idx == 2'd3) begin
                    result <= {s_sum, acc[11:0]};
                    c_out  <= s_co;
                    ovf    <= (op_a[15] == op_b[15]) && (s_sum[3] != op_a[15]);
                end
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed self-checking bench for nibble_serial_add_ctrl.
module tb_nibble_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst, start, op_sub;
    logic [15:0] a, b;
    logic busy, done, c_out, ovf;
    logic [15:0] result;
    int tests = 0;
    int fails = 0;

    nibble_serial_add_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .c_out(c_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic sub, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] er, input logic ec, input logic ev, input logic [15:0] prev);
        op_sub = sub; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_hold"}, 32'(result), 32'(prev));
            step();
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'(er));
        chk({tag, "_c_out"}, 32'(c_out), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(ev));
        step();
        chk({tag, "_done_lo"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; op_sub = 1'b0; a = 16'h1234; b = 16'h4321;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cv", 32'({c_out, ovf}), 32'd0);
        start = 1'b0; rst = 1'b0;
        step();
        do_op("add1", 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 16'h0000);
        do_op("wrap", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h5555);
        do_op("povf", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 16'h0000);
        do_op("sub1", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 16'h8000);
        do_op("sub2", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 16'hFFFE);
        // start during RUN must not disturb the operation in flight
        op_sub = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1; op_sub = 1'b1; a = 16'hAAAA; b = 16'h5555;
        step();
        step();
        start = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        step();
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_result", 32'(result), 32'h3333);
        step();
        chk("ign_idle", 32'({busy, done}), 32'd0);
        // back-to-back with start held through DONE
        op_sub = 1'b0; a = 16'h0001; b = 16'h0002; start = 1'b1;
        step();
        repeat (3) step();
        step();
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_res1", 32'(result), 32'h0003);
        a = 16'h0010; b = 16'h0020;
        step();
        start = 1'b0;
        chk("b2b_busy", 32'({busy, done}), 32'b10);
        chk("b2b_hold", 32'(result), 32'h0003);
        repeat (3) begin
            step();
            chk("b2b_nodone", 32'(done), 32'd0);
        end
        step();
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_res2", 32'(result), 32'h0030);
        step();
        // asynchronous reset at idx=2
        a = 16'h1234; b = 16'h1111; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_cv", 32'({c_out, ovf}), 32'd0);
        #1 rst = 1'b0;
        step();
        chk("arst_nodone", 32'(done), 32'd0);
        do_op("post", 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 16'h0000);
        repeat (3) begin
            step();
            chk("idle_hold", 32'(result), 32'h0100);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
